// File: rtl/div_unit_pkg.sv
// Shared types and defaults for the iterative RV32M divider.
package div_unit_pkg;

   localparam int unsigned DIV_DATA_LEN = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } div_state_e;

endpackage

// File: rtl/div_unit_if.sv
// Issue/writeback handshake bundle between the execute stage and the divider.
interface div_unit_if
   import div_unit_pkg::*;
#(
   parameter int unsigned DATA_LEN = DIV_DATA_LEN
);
   logic                in_valid;
   logic                in_ready;
   logic [DATA_LEN-1:0] NUM_A;
   logic [DATA_LEN-1:0] NUM_B;
   logic                is_sign;
   logic                is_rem;
   logic                flush;
   logic                out_valid;
   logic                out_ready;
   logic [DATA_LEN-1:0] res;

   modport master (
      output in_valid, NUM_A, NUM_B, is_sign, is_rem, flush, out_ready,
      input  in_ready, out_valid, res
   );

   modport slave (
      input  in_valid, NUM_A, NUM_B, is_sign, is_rem, flush, out_ready,
      output in_ready, out_valid, res
   );
endinterface

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, trial subtract, keep or restore.
module div_step #(
   parameter int unsigned DATA_LEN = 32
) (
   input  logic [DATA_LEN-1:0] rem_in,
   input  logic                dvd_msb,
   input  logic [DATA_LEN-1:0] divisor,
   output logic [DATA_LEN-1:0] rem_c,
   output logic                q_bit_c
);
   logic [DATA_LEN:0] shifted;
   logic [DATA_LEN:0] trial;

   // The partial remainder is always below the divisor, so DATA_LEN+1 bits hold the trial exactly.
   assign shifted = {rem_in, dvd_msb};
   assign trial   = shifted - {1'b0, divisor};
   assign q_bit_c = ~trial[DATA_LEN];
   assign rem_c   = q_bit_c ? trial[DATA_LEN-1:0] : shifted[DATA_LEN-1:0];
endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU with valid/ready handshakes.
module div_unit
   import div_unit_pkg::*;
#(
   parameter int unsigned DATA_LEN = DIV_DATA_LEN
) (
   input logic       clk,
   input logic       rst_n,
   div_unit_if.slave bus
);
   localparam int unsigned        CNT_W      = $clog2(DATA_LEN) + 1;
   localparam logic [DATA_LEN-1:0] ALL_ONES   = '1;
   localparam logic [DATA_LEN-1:0] SIGNED_MIN = {1'b1, {(DATA_LEN-1){1'b0}}};

   div_state_e          state_q, state_d;
   logic [DATA_LEN-1:0] dvd_q, dvd_d;
   logic [DATA_LEN-1:0] dsr_q, dsr_d;
   logic [DATA_LEN-1:0] rem_q, rem_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                neg_q_q, neg_q_d;
   logic                neg_r_q, neg_r_d;
   logic                is_rem_q, is_rem_d;
   logic [DATA_LEN-1:0] res_q, res_d;
   logic                in_ready_q, in_ready_d;
   logic                out_valid_q, out_valid_d;

   logic                a_neg, b_neg, ovf;
   logic [DATA_LEN-1:0] abs_a, abs_b;
   logic [DATA_LEN-1:0] rem_c, quot_fin;
   logic                q_bit_c;

   div_step #(.DATA_LEN(DATA_LEN)) u_step (
      .rem_in  (rem_q),
      .dvd_msb (dvd_q[DATA_LEN-1]),
      .divisor (dsr_q),
      .rem_c   (rem_c),
      .q_bit_c (q_bit_c)
   );

   // Operand magnitudes; -MIN wraps to 2^(DATA_LEN-1), which is the correct unsigned magnitude.
   assign a_neg    = bus.is_sign & bus.NUM_A[DATA_LEN-1];
   assign b_neg    = bus.is_sign & bus.NUM_B[DATA_LEN-1];
   assign abs_a    = a_neg ? -bus.NUM_A : bus.NUM_A;
   assign abs_b    = b_neg ? -bus.NUM_B : bus.NUM_B;
   assign ovf      = bus.is_sign & (bus.NUM_A == SIGNED_MIN) & (bus.NUM_B == ALL_ONES);
   assign quot_fin = {dvd_q[DATA_LEN-2:0], q_bit_c};

   always_comb begin
      state_d  = state_q;
      dvd_d    = dvd_q;
      dsr_d    = dsr_q;
      rem_d    = rem_q;
      cnt_d    = cnt_q;
      neg_q_d  = neg_q_q;
      neg_r_d  = neg_r_q;
      is_rem_d = is_rem_q;
      res_d    = res_q;

      case (state_q)
         ST_IDLE: begin
            if (bus.in_valid && !bus.flush) begin
               if (bus.NUM_B == '0) begin
                  res_d   = bus.is_rem ? bus.NUM_A : ALL_ONES;
                  state_d = ST_DONE;
               end else if (ovf) begin
                  res_d   = bus.is_rem ? '0 : SIGNED_MIN;
                  state_d = ST_DONE;
               end else begin
                  dvd_d    = abs_a;
                  dsr_d    = abs_b;
                  rem_d    = '0;
                  cnt_d    = CNT_W'(DATA_LEN);
                  neg_q_d  = a_neg ^ b_neg;
                  neg_r_d  = a_neg;
                  is_rem_d = bus.is_rem;
                  state_d  = ST_CALC;
               end
            end
         end
         ST_CALC: begin
            dvd_d = quot_fin;
            rem_d = rem_c;
            cnt_d = cnt_q - CNT_W'(1);
            // Last iteration: sign fix-up lands in res on the same edge as the move to DONE.
            if (cnt_q == CNT_W'(1)) begin
               if (is_rem_q) res_d = neg_r_q ? -rem_c : rem_c;
               else          res_d = neg_q_q ? -quot_fin : quot_fin;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (bus.out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      if (bus.flush) state_d = ST_IDLE;

      in_ready_d  = (state_d == ST_IDLE);
      out_valid_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         dvd_q       <= '0;
         dsr_q       <= '0;
         rem_q       <= '0;
         cnt_q       <= '0;
         neg_q_q     <= 1'b0;
         neg_r_q     <= 1'b0;
         is_rem_q    <= 1'b0;
         res_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         dvd_q       <= dvd_d;
         dsr_q       <= dsr_d;
         rem_q       <= rem_d;
         cnt_q       <= cnt_d;
         neg_q_q     <= neg_q_d;
         neg_r_q     <= neg_r_d;
         is_rem_q    <= is_rem_d;
         res_q       <= res_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.res       = res_q;
endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed RV32M cases, random ops against an arithmetic model, flush and reset.
module tb_div_unit;
   import div_unit_pkg::*;

   localparam int unsigned W    = 32;
   localparam logic [W-1:0] MINV = 32'h8000_0000;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   passed = 0;
   int   total  = 0;

   div_unit_if #(.DATA_LEN(W)) bus ();

   div_unit #(.DATA_LEN(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // RISC-V semantics from plain arithmetic; 64-bit signed math makes MIN/-1 fall out naturally.
   function automatic logic [W-1:0] ref_res(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic s, input logic r);
      longint sa, sb;
      if (b == '0) return r ? a : '1;
      if (s) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         return r ? W'(sa % sb) : W'(sa / sb);
      end
      return r ? (a % b) : (a / b);
   endfunction

   function automatic int ref_lat(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
      if (b == '0 || (s && a == MINV && b == '1)) return 1;
      return W + 1;
   endfunction

   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input logic r);
      @(negedge clk);
      bus.NUM_A    = a;
      bus.NUM_B    = b;
      bus.is_sign  = s;
      bus.is_rem   = r;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.NUM_A    = $urandom;
      bus.NUM_B    = $urandom;
      bus.is_sign  = 1'($urandom_range(0, 1));
      bus.is_rem   = 1'($urandom_range(0, 1));
   endtask

   // lat counts negedge samples after the accept edge; 0 means no result within the budget.
   task automatic wait_result(output logic [W-1:0] r, output int lat);
      lat = 0;
      r   = '0;
      for (int i = 1; i <= 200; i++) begin
         @(negedge clk);
         if (bus.out_valid === 1'b1) begin
            lat = i;
            r   = bus.res;
            break;
         end
      end
   endtask

   task automatic handshake();
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      bus.in_valid = 1'b0; bus.NUM_A = '0; bus.NUM_B = '0; bus.is_sign = 1'b0;
      bus.is_rem = 1'b0; bus.flush = 1'b0; bus.out_ready = 1'b0;
      repeat (2) @(negedge clk);
      total++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.res !== '0)
         $display("FAIL reset: in_ready=%b out_valid=%b res=%h, expected 1 0 00000000",
                  bus.in_ready, bus.out_valid, bus.res);
      else passed++;
      rst_n = 1'b1;
   endtask

   task automatic test_directed();
      logic [W-1:0] ta [12] = '{32'd100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                               32'h1234_5678, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678,
                               MINV, MINV, MINV, MINV};
      logic [W-1:0] tb [12] = '{32'd7, 32'd7, 32'd2, 32'd2, 32'd0, 32'd0, 32'd0, 32'd0,
                               32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      logic         ts [12] = '{0, 0, 1, 1, 0, 0, 1, 1, 1, 1, 0, 0};
      logic         tr [12] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
      logic [W-1:0] te [12] = '{32'd14, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
                               32'hFFFF_FFFF, 32'h1234_5678, 32'hFFFF_FFFF, 32'h1234_5678,
                               MINV, 32'd0, 32'd0, MINV};
      int           tl [12] = '{33, 33, 33, 33, 1, 1, 1, 1, 1, 1, 33, 33};
      logic [W-1:0] r;
      int           lat;
      for (int i = 0; i < 12; i++) begin
         issue(ta[i], tb[i], ts[i], tr[i]);
         wait_result(r, lat);
         total++;
         if (r !== te[i] || lat != tl[i])
            $display("FAIL directed[%0d]: res=%h lat=%0d, expected res=%h lat=%0d",
                     i, r, lat, te[i], tl[i]);
         else passed++;
         handshake();
      end
   endtask

   task automatic test_random();
      logic [W-1:0] a, b, r;
      logic         s, rm;
      int           lat, sel;
      for (int i = 0; i < 60; i++) begin
         sel = $urandom_range(0, 7);
         s   = 1'($urandom_range(0, 1));
         rm  = 1'($urandom_range(0, 1));
         a   = $urandom;
         b   = $urandom >> $urandom_range(0, 31);
         if (sel == 0) b = '0;
         if (sel == 1) begin a = MINV; b = '1; end
         issue(a, b, s, rm);
         wait_result(r, lat);
         total++;
         if (r !== ref_res(a, b, s, rm) || lat != ref_lat(a, b, s))
            $display("FAIL random[%0d] a=%h b=%h s=%b rem=%b: res=%h lat=%0d, expected res=%h lat=%0d",
                     i, a, b, s, rm, r, lat, ref_res(a, b, s, rm), ref_lat(a, b, s));
         else passed++;
         handshake();
      end
   endtask

   task automatic test_backpressure();
      logic [W-1:0] r;
      int           lat;
      issue(32'd1000, 32'd3, 1'b0, 1'b0);
      wait_result(r, lat);
      total++;
      if (r !== 32'd333) $display("FAIL bp_result: res=%h expected %h", r, 32'd333);
      else passed++;
      for (int i = 0; i < 10; i++) begin
         bus.NUM_A = $urandom;
         bus.in_valid = 1'b1;
         @(negedge clk);
         total++;
         if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.res !== 32'd333)
            $display("FAIL bp_hold[%0d]: out_valid=%b in_ready=%b res=%h, expected 1 0 %h",
                     i, bus.out_valid, bus.in_ready, bus.res, 32'd333);
         else passed++;
      end
      bus.in_valid = 1'b0;
      handshake();
      total++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0)
         $display("FAIL bp_release: in_ready=%b out_valid=%b, expected 1 0", bus.in_ready, bus.out_valid);
      else passed++;
   endtask

   task automatic test_flush();
      logic [W-1:0] r;
      int           lat, seen;
      // Kill in the middle of iterating.
      issue(32'd100, 32'd7, 1'b0, 1'b0);
      repeat (5) @(posedge clk);
      @(negedge clk) bus.flush = 1'b1;
      @(posedge clk);
      #1 bus.flush = 1'b0;
      total++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
         $display("FAIL flush_calc: out_valid=%b in_ready=%b, expected 0 1", bus.out_valid, bus.in_ready);
      else passed++;
      seen = 0;
      repeat (40) begin @(negedge clk); if (bus.out_valid === 1'b1) seen++; end
      total++;
      if (seen != 0) $display("FAIL flush_noresult: out_valid cycles=%0d expected 0", seen);
      else passed++;
      issue(32'd100, 32'd7, 1'b0, 1'b0);
      wait_result(r, lat);
      total++;
      if (r !== 32'd14 || lat != 33)
         $display("FAIL flush_after: res=%h lat=%0d, expected 0000000e 33", r, lat);
      else passed++;
      handshake();
      // Flush alongside an issue in IDLE must not accept it.
      @(negedge clk);
      bus.NUM_A = 32'd5; bus.NUM_B = '0; bus.is_sign = 1'b0; bus.is_rem = 1'b0;
      bus.in_valid = 1'b1; bus.flush = 1'b1;
      @(posedge clk);
      #1 begin bus.in_valid = 1'b0; bus.flush = 1'b0; end
      seen = 0;
      repeat (5) begin @(negedge clk); if (bus.out_valid === 1'b1) seen++; end
      total++;
      if (seen != 0 || bus.in_ready !== 1'b1)
         $display("FAIL flush_idle: out_valid cycles=%0d in_ready=%b, expected 0 1", seen, bus.in_ready);
      else passed++;
      // Flush coinciding with the output handshake.
      issue(32'd9, 32'd0, 1'b1, 1'b1);
      wait_result(r, lat);
      total++;
      if (r !== 32'd9 || lat != 1) $display("FAIL flush_done_res: res=%h lat=%0d, expected 00000009 1", r, lat);
      else passed++;
      bus.flush = 1'b1;
      handshake();
      bus.flush = 1'b0;
      total++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
         $display("FAIL flush_done: out_valid=%b in_ready=%b, expected 0 1", bus.out_valid, bus.in_ready);
      else passed++;
   endtask

   task automatic test_async_reset();
      logic [W-1:0] r;
      int           lat, seen;
      issue(32'd100, 32'd7, 1'b0, 1'b1);
      repeat (10) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      total++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.res !== '0)
         $display("FAIL async_reset: in_ready=%b out_valid=%b res=%h, expected 1 0 00000000",
                  bus.in_ready, bus.out_valid, bus.res);
      else passed++;
      @(negedge clk) rst_n = 1'b1;
      seen = 0;
      repeat (40) begin @(negedge clk); if (bus.out_valid === 1'b1) seen++; end
      total++;
      if (seen != 0) $display("FAIL reset_noresult: out_valid cycles=%0d expected 0", seen);
      else passed++;
      issue(32'd100, 32'd7, 1'b0, 1'b1);
      wait_result(r, lat);
      total++;
      if (r !== 32'd2 || lat != 33) $display("FAIL reset_after: res=%h lat=%0d, expected 00000002 33", r, lat);
      else passed++;
      handshake();
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_backpressure();
      test_flush();
      test_async_reset();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
